// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter/sequencer owning one WIDTH-bit register shared by four requesters.
// Optional grant-length limit enabled by defining HOLD_TIMEOUT_EN (MAX_HOLD cycles).
module reg_share_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         req,
  input  logic [3:0]         clr,
  input  logic [3:0]         set,
  input  logic [3:0]         wr_en,
  input  logic [4*WIDTH-1:0] wr_data,
  output logic [3:0]         grant,
  output logic [1:0]         owner,
  output logic               busy,
  output logic [WIDTH-1:0]   q
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("MAX_HOLD must be at least 2");
  end

  // Returns {found, index} of the first requester at or after the pointer, wrapping mod 4.
  function automatic logic [2:0] f_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + k[1:0];
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  state_t           r_state, w_state;
  logic [1:0]       r_ptr, w_ptr;
  logic [1:0]       r_owner, w_owner;
  logic [3:0]       r_grant, w_grant;
  logic [WIDTH-1:0] r_q, w_q;
  logic [2:0]       w_pick;
  logic [WIDTH-1:0] w_slice [4];

  for (genvar i = 0; i < 4; i++) begin : g_slice
    assign w_slice[i] = wr_data[i*WIDTH +: WIDTH];
  end

  assign w_pick = f_pick(req, r_ptr);

`ifdef HOLD_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  logic [HW-1:0] r_hold, w_hold;
`endif

  // Next-state, arbitration and command decode.
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_owner = r_owner;
    w_grant = r_grant;
    w_q     = r_q;
`ifdef HOLD_TIMEOUT_EN
    w_hold  = r_hold;
`endif
    case (r_state)
      ST_IDLE, ST_RELEASE: begin
        if (w_pick[2]) begin
          w_state = ST_OWN;
          w_owner = w_pick[1:0];
          w_grant = 4'b0001 << w_pick[1:0];
`ifdef HOLD_TIMEOUT_EN
          w_hold  = {HW{1'b0}};
`endif
        end else begin
          w_state = ST_IDLE;
          w_grant = 4'b0000;
        end
      end
      ST_OWN: begin
`ifdef HOLD_TIMEOUT_EN
        w_hold = r_hold + HW'(1);
`endif
        if (req[r_owner]) begin
          if (clr[r_owner]) begin
            w_q = {WIDTH{1'b0}};
          end else if (set[r_owner]) begin
            w_q = {WIDTH{1'b1}};
          end else if (wr_en[r_owner]) begin
            w_q = w_slice[r_owner];
          end else begin
            w_q = r_q;
          end
`ifdef HOLD_TIMEOUT_EN
          // Forced handover: the command of the final cycle still executes.
          if (r_hold == HOLD_LAST) begin
            w_state = ST_RELEASE;
            w_ptr   = r_owner + 2'd1;
            w_grant = 4'b0000;
          end else begin
            w_state = ST_OWN;
          end
`endif
        end else begin
          w_state = ST_RELEASE;
          w_ptr   = r_owner + 2'd1;
          w_grant = 4'b0000;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_grant = 4'b0000;
      end
    endcase
  end

  // State, pointer, grant and shared register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
      r_grant <= 4'b0000;
      r_q     <= {WIDTH{1'b0}};
`ifdef HOLD_TIMEOUT_EN
      r_hold  <= {HW{1'b0}};
`endif
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_owner <= w_owner;
      r_grant <= w_grant;
      r_q     <= w_q;
`ifdef HOLD_TIMEOUT_EN
      r_hold  <= w_hold;
`endif
    end
  end

  assign grant = r_grant;
  assign owner = r_owner;
  assign busy  = |r_grant;
  assign q     = r_q;

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit storage register among four requesters. The block owns the register and grants exclusive access to one requester at a time. The owner may clear, set or load the register, with priority clear > set > load, the same as the set/reset flip-flops in the datapath. It sits between the requester blocks and the shared register and is the only writer of that register.

## Interface
- WIDTH, 8, width of the shared register and of each requester's data slice
- MAX_HOLD, 8, maximum grant length in cycles when HOLD_TIMEOUT_EN is defined; must be ≥ 2
- clk  input  1  single clock; all state changes on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  4  per-requester access request, level-held
- clr  input  4  per-requester synchronous clear command, active-high
- set  input  4  per-requester synchronous set command (all ones), active-high
- wr_en  input  4  per-requester load command, active-high
- wr_data  input  4*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
- grant  output  4  one-hot grant, registered
- owner  output  2  index of the current or last owner, registered
- busy  output  1  high when any grant bit is high
- q  output  WIDTH  shared register contents

## Operation
- States:
  - IDLE: grant = 0.
  - OWN: grant[owner] = 1.
  - RELEASE: grant = 0 for exactly one cycle.
- Rotation pointer ptr (2 bits) gives the highest-priority index. The search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
- IDLE: if any req bit is high at the edge, the first requester in search order becomes owner and the state moves to OWN. Otherwise the state stays in IDLE.
- OWN, with req[owner] high, executes the owner's command at the edge:
  - clr[owner]: q ← 0
  - else set[owner]: q ← all ones
  - else wr_en[owner]: q ← owner's wr_data slice
  - else q holds
- OWN, with req[owner] low: no command executes, ptr ← owner+1, and the state moves to RELEASE.
- Commands from non-owners, and all commands in IDLE or RELEASE, are ignored.
- RELEASE arbitrates exactly like IDLE using the updated ptr, moving to OWN or IDLE. The released requester therefore ranks lowest.
- busy = |grant. owner holds its value in IDLE and RELEASE.

## Timing
- Reset (asynchronous, reset_n low): state IDLE, ptr 0, owner 0, grant 0, busy 0, q 0, hold counter 0. Outputs change immediately, not at a clock edge.
- Reset asserted mid-grant aborts the grant with no command executed. After release, the first grant follows the IDLE rules with ptr 0.
- Grant latency: req high before edge N in IDLE gives grant high after edge N.
- Command latency: a command sampled at an edge with grant high gives q updated after that same edge.
- Handover: owner drops req before edge N, so grant = 0 after edge N (RELEASE). The next owner's grant rises after edge N+1, which is a minimum one-cycle gap.
- Simultaneous requests are resolved strictly by the pointer. Requester 0 wins the first arbitration after reset.
- Requests raised during OWN wait and do not pre-empt the owner.
- The hold counter clears on entry to OWN and increments on every OWN edge.

## Configuration
- HOLD_TIMEOUT_EN defined:
  - At the edge where the hold counter equals MAX_HOLD-1 and req[owner] is still high, the owner's command executes, ptr ← owner+1, and the state moves to RELEASE.
  - Grant lasts at most MAX_HOLD cycles.
  - A requester that keeps req high is re-granted only after the other pending requesters are served.
- HOLD_TIMEOUT_EN undefined:
  - No counter is implemented.
  - Grant holds until req[owner] drops, so a requester may hold the register indefinitely.

## Test plan
- Reset: reset_n=0 mid-operation with grant=0100 and q=8'h5A. Required: grant=0, busy=0, q=0, owner=0 immediately, without a clock edge.
- Single load: req[2]=1 from IDLE. Required: grant=0100 after 1 edge. Then wr_en[2]=1 with slice 8'hA5 gives q=8'hA5 after the next edge, and wr_en[1] asserted in the same cycle is ignored.
- Command priority: owner 0 drives clr=set=wr_en=1, giving q=0x00. Next, set=wr_en=1 gives q=0xFF. Next, wr_en only with data 0x3C gives q=0x3C.
- Rotation: req=1111 held, each owner holds for 2 cycles then drops and re-raises. Required: grant order 0001, 0010, 0100, 1000, 0001, with one grant=0 cycle between grants.
- Timeout (HOLD_TIMEOUT_EN, MAX_HOLD=4): req=0011 held. Required: grant=0001 for exactly 4 cycles, then 1 cycle of 0, then 0010. Without the macro, grant=0001 persists for more than 20 cycles.
- Ignored commands: with grant=0010, clr[3]=1 and set[0]=1 leave q unchanged. In RELEASE, owner commands leave q unchanged.
